// File: rtl/bram_stream_reader.sv
// bram_stream_reader: streams a burst of consecutive BRAM words
// out through a valid/ready port, with a 2-entry skid buffer.
module bram_stream_reader #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic [ADDR_W-1:0] read_addr,
  input  logic [DATA_W-1:0] read_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } state_t;

  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t state;
  state_t state_nx;
  logic done_nx;

  logic [ADDR_W:0] len_sat;
  logic [ADDR_W:0] rd_left;
  logic [ADDR_W:0] out_left;
  logic rd_vld;
  logic [1:0] cnt;
  logic [DATA_W-1:0] buf0;
  logic [DATA_W-1:0] buf1;
  logic [2:0] credit;
  logic pop;
  logic push;
  logic issue;
  logic accept;

  assign len_sat = (length > MAX_LEN) ? MAX_LEN : length;
  assign accept = (state == IDLE) && start;

  assign out_valid = (cnt != 2'd0);
  assign out_data = buf0;
  assign out_last = out_valid && (out_left == ONE);
  assign busy = (state != IDLE);

  assign pop = out_valid && out_ready;
  assign push = rd_vld;

  // Occupancy after this edge's pop, plus the word returning now;
  // a new read may only be launched if room for it is guaranteed.
  assign credit = {1'b0, cnt} + {2'b00, rd_vld} - {2'b00, pop};
  assign issue = (state == STREAM) && (rd_left != '0) &&
                 (credit < 3'd2);

  // Burst sequencing: next state and completion pulse.
  always_comb begin
    state_nx = state;
    done_nx = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (len_sat == '0) begin
            done_nx = 1'b1;
          end else begin
            state_nx = STREAM;
          end
        end
      end
      STREAM: begin
        if (issue && (rd_left == ONE)) begin
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && out_last) begin
          state_nx = IDLE;
          done_nx = 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State register and registered done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      done <= 1'b0;
    end else begin
      state <= state_nx;
      done <= done_nx;
    end
  end

  // Read side: address generation and read-return tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_addr <= '0;
      rd_left <= '0;
      rd_vld <= 1'b0;
    end else if (accept) begin
      read_addr <= base_addr;
      rd_left <= len_sat;
      rd_vld <= 1'b0;
    end else begin
      rd_vld <= issue;
      if (issue) begin
        rd_left <= rd_left - ONE;
        if (rd_left != ONE) begin
          read_addr <= read_addr + 1'b1;
        end
      end
    end
  end

  // Output side: 2-entry FIFO with head in buf0, and word countdown.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= 2'd0;
      buf0 <= '0;
      buf1 <= '0;
      out_left <= '0;
    end else begin
      if (accept) begin
        out_left <= len_sat;
      end else if (pop) begin
        out_left <= out_left - ONE;
      end
      unique case ({push, pop})
        2'b11: begin
          if (cnt == 2'd2) begin
            buf0 <= buf1;
            buf1 <= read_data;
          end else begin
            buf0 <= read_data;
          end
        end
        2'b10: begin
          if (cnt == 2'd0) begin
            buf0 <= read_data;
          end else begin
            buf1 <= read_data;
          end
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          buf0 <= buf1;
          cnt <= cnt - 2'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
// tb_bram_stream_reader: randomized bursts against a queue-based
// reference of the words a burst must deliver.
module tb_bram_stream_reader;

  localparam int AW = 12;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic [AW-1:0] base_addr;
  logic [AW:0] length;
  logic [AW-1:0] read_addr;
  logic [DW-1:0] read_data;
  logic [DW-1:0] out_data;
  logic out_valid;
  logic out_ready;
  logic out_last;
  logic busy;
  logic done;

  logic [DW-1:0] mem [0:4095];

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] rx_q[$];
  bit rx_last_q[$];
  int rx_cyc_q[$];
  logic [DW-1:0] exp_q[$];
  int done_cnt;
  int done_cyc;
  logic busy_at_done;
  int stall_err;
  int valid_seen;
  int timed_out;
  logic [AW-1:0] addr_c1;

  bram_stream_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .base_addr(base_addr),
    .length(length),
    .read_addr(read_addr),
    .read_data(read_data),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last(out_last),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) read_data <= mem[read_addr];

  // Reference: a burst yields min(len,4096) words from
  // consecutive addresses modulo 4096.
  function automatic void build_exp(input int b, input int l);
    int n;
    exp_q.delete();
    n = (l > 4096) ? 4096 : l;
    for (int i = 0; i < n; i++) exp_q.push_back(mem[(b + i) % 4096]);
  endfunction

  task automatic do_burst(input int b, input int l, input int rdy_pct,
                          input int inj_k, input bit stop_at_done,
                          input int max_cyc);
    logic [DW-1:0] hold_d;
    logic hold_l;
    bit stalled;
    bit fin;
    int k;
    rx_q.delete();
    rx_last_q.delete();
    rx_cyc_q.delete();
    done_cnt = 0;
    done_cyc = 0;
    busy_at_done = 1'b0;
    stall_err = 0;
    valid_seen = 0;
    timed_out = 0;
    stalled = 0;
    fin = 0;
    hold_d = '0;
    hold_l = 1'b0;
    k = 0;
    start = 1'b1;
    base_addr = AW'(b);
    length = (AW + 1)'(l);
    out_ready = ($urandom_range(99) < rdy_pct);
    while (!fin) begin
      @(posedge clk);
      #1;
      k++;
      if (k == inj_k) begin
        start = 1'b1;
        base_addr = AW'($urandom);
        length = (AW + 1)'($urandom_range(1, 20));
      end else begin
        start = 1'b0;
      end
      out_ready = ($urandom_range(99) < rdy_pct);
      @(negedge clk);
      if (k == 1) addr_c1 = read_addr;
      if (stalled && !(out_valid && out_data === hold_d &&
                       out_last === hold_l)) stall_err++;
      stalled = out_valid && !out_ready;
      hold_d = out_data;
      hold_l = out_last;
      if (out_valid) valid_seen++;
      if (out_valid && out_ready) begin
        rx_q.push_back(out_data);
        rx_last_q.push_back(out_last);
        rx_cyc_q.push_back(k);
      end
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          done_cyc = k;
          busy_at_done = busy;
        end
      end
      if (done_cnt > 0 && (stop_at_done || k >= done_cyc + 2)) fin = 1;
      if (k >= max_cyc) begin
        timed_out = 1;
        fin = 1;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    out_ready = 1'b0;
    base_addr = '0;
    length = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid, out_last, busy, done, read_addr, out_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got v%b l%b b%b d%b a%h d%h want zero",
               out_valid, out_last, busy, done, read_addr, out_data);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle got busy %b valid %b want 0 0",
               busy, out_valid);
    end
  endtask

  task automatic test_basic;
    int n;
    build_exp(16, 8);
    do_burst(16, 8, 100, 0, 0, 200);
    n = rx_q.size();
    checks++;
    if (timed_out != 0) begin
      errors++;
      $display("FAIL basic_timeout got %0d want 0", timed_out);
    end
    checks++;
    if (addr_c1 !== 12'h010) begin
      errors++;
      $display("FAIL basic_first_addr got %h want 010", addr_c1);
    end
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL basic_count got %0d want 8", n);
    end
    for (int i = 0; i < n && i < 8; i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL basic_word%0d got %h want %h", i, rx_q[i], exp_q[i]);
      end
      checks++;
      if (rx_last_q[i] !== (i == 7)) begin
        errors++;
        $display("FAIL basic_last%0d got %b want %b", i, rx_last_q[i], i == 7);
      end
      checks++;
      if (rx_cyc_q[i] != rx_cyc_q[0] + i) begin
        errors++;
        $display("FAIL basic_cycle%0d got %0d want %0d", i, rx_cyc_q[i],
                 rx_cyc_q[0] + i);
      end
    end
    if (n > 0) begin
      checks++;
      if (rx_cyc_q[0] < 3) begin
        errors++;
        $display("FAIL basic_latency got %0d want >=3", rx_cyc_q[0]);
      end
      checks++;
      if (done_cyc != rx_cyc_q[n-1] + 1) begin
        errors++;
        $display("FAIL basic_done_cycle got %0d want %0d", done_cyc,
                 rx_cyc_q[n-1] + 1);
      end
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL basic_done_count got %0d want 1", done_cnt);
    end
    checks++;
    if (busy_at_done !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy_at_done got %b want 0", busy_at_done);
    end
  endtask

  task automatic test_wrap;
    int n;
    build_exp(12'hFFE, 4);
    do_burst(12'hFFE, 4, 100, 0, 0, 100);
    n = rx_q.size();
    checks++;
    if (n != 4 || timed_out != 0) begin
      errors++;
      $display("FAIL wrap_count got %0d want 4 (timeout %0d)", n, timed_out);
    end
    for (int i = 0; i < n && i < 4; i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL wrap_word%0d got %h want %h", i, rx_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_stall;
    int n;
    int b;
    b = int'($urandom_range(0, 4095));
    build_exp(b, 16);
    do_burst(b, 16, 50, 0, 0, 400);
    n = rx_q.size();
    checks++;
    if (n != 16 || timed_out != 0) begin
      errors++;
      $display("FAIL stall_count got %0d want 16 (timeout %0d)", n, timed_out);
    end
    for (int i = 0; i < n && i < 16; i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i] || rx_last_q[i] !== (i == 15)) begin
        errors++;
        $display("FAIL stall_word%0d got %h/%b want %h/%b", i, rx_q[i],
                 rx_last_q[i], exp_q[i], i == 15);
      end
    end
    checks++;
    if (stall_err != 0) begin
      errors++;
      $display("FAIL stall_stable got %0d changes want 0", stall_err);
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL stall_done got %0d want 1", done_cnt);
    end
  endtask

  task automatic test_zero;
    do_burst(int'($urandom_range(0, 4095)), 0, 100, 0, 0, 20);
    checks++;
    if (valid_seen != 0) begin
      errors++;
      $display("FAIL zero_valid got %0d want 0", valid_seen);
    end
    checks++;
    if (done_cnt != 1 || done_cyc != 1) begin
      errors++;
      $display("FAIL zero_done got count %0d cycle %0d want 1 1",
               done_cnt, done_cyc);
    end
  endtask

  task automatic test_saturate;
    int n;
    int b;
    int bad;
    b = int'($urandom_range(0, 4095));
    build_exp(b, 5000);
    do_burst(b, 5000, 100, 0, 0, 4500);
    n = rx_q.size();
    bad = 0;
    checks++;
    if (n != 4096 || timed_out != 0) begin
      errors++;
      $display("FAIL sat_count got %0d want 4096 (timeout %0d)", n, timed_out);
    end
    for (int i = 0; i < n && i < 4096; i++) begin
      if (rx_q[i] !== exp_q[i]) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL sat_words got %0d wrong want 0", bad);
    end
    checks++;
    if (n > 0 && rx_last_q[n-1] !== 1'b1) begin
      errors++;
      $display("FAIL sat_last got %b want 1", rx_last_q[n-1]);
    end
  endtask

  task automatic test_ignore_start;
    int n;
    int b;
    b = int'($urandom_range(0, 4095));
    build_exp(b, 12);
    do_burst(b, 12, 70, 5, 0, 300);
    n = rx_q.size();
    checks++;
    if (n != 12 || timed_out != 0) begin
      errors++;
      $display("FAIL ignore_count got %0d want 12 (timeout %0d)", n, timed_out);
    end
    for (int i = 0; i < n && i < 12; i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL ignore_word%0d got %h want %h", i, rx_q[i], exp_q[i]);
      end
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL ignore_done got %0d want 1", done_cnt);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    int b;
    b = int'($urandom_range(0, 4095));
    build_exp(b, 5);
    do_burst(b, 5, 100, 0, 1, 100);
    n = rx_q.size();
    checks++;
    if (n != 5 || timed_out != 0) begin
      errors++;
      $display("FAIL b2b_first got %0d want 5 (timeout %0d)", n, timed_out);
    end
    b = int'($urandom_range(0, 4095));
    build_exp(b, 6);
    do_burst(b, 6, 100, 0, 0, 100);
    n = rx_q.size();
    checks++;
    if (n != 6 || timed_out != 0) begin
      errors++;
      $display("FAIL b2b_second got %0d want 6 (timeout %0d)", n, timed_out);
    end
    for (int i = 0; i < n && i < 6; i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL b2b_word%0d got %h want %h", i, rx_q[i], exp_q[i]);
      end
    end
    if (n > 0) begin
      checks++;
      if (rx_cyc_q[0] != 3) begin
        errors++;
        $display("FAIL b2b_latency got %0d want 3", rx_cyc_q[0]);
      end
    end
  endtask

  task automatic test_reset_mid;
    int hs;
    int bad;
    int b;
    hs = 0;
    bad = 0;
    start = 1'b1;
    base_addr = AW'($urandom);
    length = 13'd10;
    out_ready = 1'b1;
    for (int k = 0; k < 50 && hs < 3; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      if (out_valid && out_ready) hs++;
    end
    checks++;
    if (hs != 3) begin
      errors++;
      $display("FAIL rstmid_reach got %0d words want 3", hs);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if ({out_valid, out_last, busy, done, read_addr, out_data} !== '0) begin
      errors++;
      $display("FAIL rstmid_async got v%b l%b b%b d%b a%h d%h want zero",
               out_valid, out_last, busy, done, read_addr, out_data);
    end
    repeat (3) begin
      @(negedge clk);
      if (done || busy || out_valid) bad++;
    end
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done || busy || out_valid) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rstmid_idle got %0d active cycles want 0", bad);
    end
    b = int'($urandom_range(0, 4095));
    build_exp(b, 6);
    do_burst(b, 6, 100, 0, 0, 100);
    checks++;
    if (rx_q.size() != 6 || done_cnt != 1) begin
      errors++;
      $display("FAIL rstmid_restart got %0d words %0d done want 6 1",
               rx_q.size(), done_cnt);
    end
    for (int i = 0; i < rx_q.size() && i < 6; i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rstmid_word%0d got %h want %h", i, rx_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random;
    int b;
    int l;
    int bad;
    for (int r = 0; r < 4; r++) begin
      b = int'($urandom_range(0, 4095));
      l = int'($urandom_range(1, 40));
      build_exp(b, l);
      do_burst(b, l, int'($urandom_range(30, 100)), 0, 0, 600);
      bad = 0;
      for (int i = 0; i < rx_q.size() && i < l; i++) begin
        if (rx_q[i] !== exp_q[i]) bad++;
      end
      checks++;
      if (rx_q.size() != l || bad != 0 || done_cnt != 1 || stall_err != 0) begin
        errors++;
        $display("FAIL random%0d got %0d words %0d bad %0d done %0d unstable want %0d 0 1 0",
                 r, rx_q.size(), bad, done_cnt, stall_err, l);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = DW'(i);
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_zero();
    test_saturate();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
